// File: rtl/usb_debug_pkg.sv
// Shared types, widths and helpers for the USB debug-channel DMA engine.
package usb_debug_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 20;
  localparam int unsigned ADDR_W         = 24;
  localparam int unsigned BANK_W         = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWaitAck,
    StSend
  } e_dma_state;

  // Bytes to emit from the next word: a full word, or the tail of the transfer.
  function automatic logic [2:0] word_bytes(input logic [LEN_W-1:0] remaining);
    return (remaining >= LEN_W'(BYTES_PER_WORD)) ? 3'(BYTES_PER_WORD) : remaining[2:0];
  endfunction

endpackage

// File: rtl/usb_debug_dma_serializer.sv
// Splits a 32-bit word into 1..4 bytes, MSB first, one per cycle while the sink is not full.
module usb_debug_dma_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] word,
  input  logic [2:0]  count,
  input  logic        tx_full,
  output logic        tx_write,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [31:0] shift;
  logic [2:0]  left;

  // The write decision uses this cycle's full, so a write never follows a full cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift    <= '0;
      left     <= '0;
      tx_write <= 1'b0;
      tx_data  <= '0;
      done     <= 1'b0;
    end else if (flush) begin
      left     <= '0;
      tx_write <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      shift    <= word;
      left     <= count;
      tx_write <= 1'b0;
      done     <= 1'b0;
    end else if (left != 3'd0 && !tx_full) begin
      tx_write <= 1'b1;
      tx_data  <= shift[31:24];
      shift    <= {shift[23:0], 8'h00};
      left     <= left - 3'd1;
      done     <= (left == 3'd1);
    end else begin
      tx_write <= 1'b0;
      done     <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_debug_dma.sv
// Debug DMA: reads a byte-length region from memory and streams it into the USB TX FIFO.
// Optional feature: define USB_DEBUG_DMA_ABORT_EN to add the i_abort port.
module usb_debug_dma
  import usb_debug_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [BANK_W-1:0] i_bank,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LEN_W-1:0]  i_length,
`ifdef USB_DEBUG_DMA_ABORT_EN
  input  logic              i_abort,
`endif
  input  logic              i_mem_busy,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_data,
  input  logic              i_tx_full,
  output logic              o_busy,
  output logic              o_mem_request,
  output logic [BANK_W-1:0] o_mem_bank,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_tx_write,
  output logic [7:0]        o_tx_data
);

  e_dma_state       state;
  logic [LEN_W-1:0] remaining;
  logic             abort;
  logic             abort_pend;
  logic             ser_load;
  logic             ser_flush;
  logic             ser_done;
  logic [2:0]       ser_count;

`ifdef USB_DEBUG_DMA_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  // An aborted read still has to be drained; its data never reaches the serializer.
  assign ser_load  = (state == StWaitAck) && i_mem_ack && !(abort || abort_pend);
  assign ser_flush = (state == StSend) && abort;
  assign ser_count = word_bytes(remaining);

  usb_debug_dma_serializer u_serializer (
    .clk      (i_clk),
    .reset    (i_reset),
    .load     (ser_load),
    .flush    (ser_flush),
    .word     (i_mem_data),
    .count    (ser_count),
    .tx_full  (i_tx_full),
    .tx_write (o_tx_write),
    .tx_data  (o_tx_data),
    .done     (ser_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= StIdle;
      remaining     <= '0;
      abort_pend    <= 1'b0;
      o_busy        <= 1'b0;
      o_mem_request <= 1'b0;
      o_mem_bank    <= '0;
      o_mem_address <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          abort_pend <= 1'b0;
          if (i_start && i_length != '0) begin
            state         <= StFetch;
            remaining     <= i_length;
            o_busy        <= 1'b1;
            o_mem_request <= 1'b1;
            o_mem_bank    <= i_bank;
            o_mem_address <= i_address;
          end
        end
        StFetch: begin
          // Acceptance wins over a same-cycle abort so the read is drained, not orphaned.
          if (!i_mem_busy) begin
            state         <= StWaitAck;
            o_mem_request <= 1'b0;
            o_mem_address <= o_mem_address + ADDR_W'(1);
            abort_pend    <= abort;
          end else if (abort) begin
            state         <= StIdle;
            o_mem_request <= 1'b0;
            o_busy        <= 1'b0;
          end
        end
        StWaitAck: begin
          if (abort) abort_pend <= 1'b1;
          if (i_mem_ack) begin
            if (abort || abort_pend) begin
              state  <= StIdle;
              o_busy <= 1'b0;
            end else begin
              state <= StSend;
            end
          end
        end
        StSend: begin
          if (abort) begin
            state  <= StIdle;
            o_busy <= 1'b0;
          end else begin
            if (o_tx_write) remaining <= remaining - LEN_W'(1);
            if (ser_done) begin
              if (remaining == LEN_W'(1)) begin
                state  <= StIdle;
                o_busy <= 1'b0;
              end else begin
                state         <= StFetch;
                o_mem_request <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
